// File: rtl/sequence_step_fetcher.sv
// sequence_step_fetcher: walks a BRAM of DATA_W-bit step words and presents one word per
// step on seq_data. Each word is held for step_period clocks, which is clamped to a minimum of 4.
// The next word is prefetched so that steps change on exact cycle boundaries.
// seq_data is all-zero while idle or done.
// Optional feature macro: SEQ_FETCH_LOOP_EN. When it is defined, loop_mode wraps the sequence
// and repeat_count counts passes. When it is undefined, loop_mode is ignored and repeat_count is 0.
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   enable                level; a rising edge starts a run, low aborts it
//   step_period           clocks per step (values below 4 are clamped to 4)
//   seq_len               number of steps; 0 = empty sequence
//   loop_mode             wrap to step 0 after the last step
//   bram_en/addr/rdata    BRAM read port; rdata is valid 1 clk after bram_en
//   seq_data, seq_valid   current step word and its live flag
//   step_strobe           1-clk pulse when seq_data takes a new word
//   step_index            index of the word on seq_data
//   repeat_count          completed passes in loop mode (saturating)
//   busy, done            run in progress / non-loop run finished
module sequence_step_fetcher #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              enable,
   input  logic [CNT_W-1:0]  step_period,
   input  logic [ADDR_W:0]   seq_len,
   input  logic              loop_mode,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic [DATA_W-1:0] seq_data,
   output logic              seq_valid,
   output logic              step_strobe,
   output logic [ADDR_W-1:0] step_index,
   output logic [CNT_W-1:0]  repeat_count,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_FILL  = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state,     w_state_nxt;
   logic                r_en_prev;
   logic [CNT_W-1:0]    r_period,    w_period_nxt;
   logic [LEN_W-1:0]    r_len,       w_len_nxt;
   logic                r_loop,      w_loop_nxt;
   logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
   logic                r_first,     w_first_nxt;
   logic                r_rd_v1;
   logic [DATA_W-1:0]   r_buf,       w_buf_nxt;
   logic                r_bram_en,   w_bram_en_nxt;
   logic [ADDR_W-1:0]   r_bram_addr, w_bram_addr_nxt;
   logic [DATA_W-1:0]   r_seq_data,  w_seq_data_nxt;
   logic                r_seq_valid, w_seq_valid_nxt;
   logic                r_strobe,    w_strobe_nxt;
   logic [ADDR_W-1:0]   r_index,     w_index_nxt;
   logic [CNT_W-1:0]    r_repeat,    w_repeat_nxt;
   logic                r_busy,      w_busy_nxt;
   logic                r_done,      w_done_nxt;

   logic                w_loop_in;
   logic                w_last;
   logic                w_has_next;
   logic [ADDR_W-1:0]   w_next_addr;

`ifdef SEQ_FETCH_LOOP_EN
   assign w_loop_in = loop_mode;
`else
   logic w_unused_loop;
   assign w_unused_loop = loop_mode;
   assign w_loop_in     = 1'b0;
`endif

   // Position of the word on seq_data within the latched sequence.
   assign w_last      = (LEN_W'(r_index) == (r_len - LEN_W'(1)));
   assign w_has_next  = !w_last || r_loop;
   assign w_next_addr = w_last ? '0 : (r_index + ADDR_W'(1));

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_period_nxt    = r_period;
      w_len_nxt       = r_len;
      w_loop_nxt      = r_loop;
      w_cnt_nxt       = r_cnt;
      w_first_nxt     = r_first;
      w_buf_nxt       = r_buf;
      w_bram_en_nxt   = 1'b0;
      w_bram_addr_nxt = r_bram_addr;
      w_seq_data_nxt  = r_seq_data;
      w_seq_valid_nxt = r_seq_valid;
      w_strobe_nxt    = 1'b0;
      w_index_nxt     = r_index;
      w_repeat_nxt    = r_repeat;
      w_busy_nxt      = r_busy;
      w_done_nxt      = r_done;

      // BRAM data lands one clock after the read enable.
      if (r_rd_v1 && ((r_state == S_FILL) || (r_state == S_RUN))) begin
         w_buf_nxt = bram_rdata;
      end

      if (!enable) begin
         // Abort: return to idle and discard anything in flight.
         w_state_nxt     = S_IDLE;
         w_cnt_nxt       = '0;
         w_first_nxt     = 1'b0;
         w_buf_nxt       = '0;
         w_bram_addr_nxt = '0;
         w_seq_data_nxt  = '0;
         w_seq_valid_nxt = 1'b0;
         w_index_nxt     = '0;
         w_repeat_nxt    = '0;
         w_busy_nxt      = 1'b0;
         w_done_nxt      = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_en_prev) begin
                  w_period_nxt = (step_period < CNT_W'(4)) ? CNT_W'(4) : step_period;
                  w_len_nxt    = seq_len;
                  w_loop_nxt   = w_loop_in;
                  w_index_nxt  = '0;
                  w_repeat_nxt = '0;
                  if (seq_len == '0) begin
                     w_state_nxt = S_DONE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt     = S_PRIME;
                     w_bram_en_nxt   = 1'b1;
                     w_bram_addr_nxt = '0;
                     w_busy_nxt      = 1'b1;
                  end
               end
            end
            S_PRIME: begin
               w_state_nxt = S_FILL;
            end
            S_FILL: begin
               // Counter at 0 makes the first RUN cycle load step 0.
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
               w_first_nxt = 1'b1;
            end
            S_RUN: begin
               // Prefetch the following step the clock after each strobe.
               if (r_strobe && w_has_next) begin
                  w_bram_en_nxt   = 1'b1;
                  w_bram_addr_nxt = w_next_addr;
               end
               if (r_cnt == '0) begin
                  if (r_first) begin
                     w_first_nxt     = 1'b0;
                     w_seq_data_nxt  = r_buf;
                     w_seq_valid_nxt = 1'b1;
                     w_strobe_nxt    = 1'b1;
                     w_index_nxt     = '0;
                     w_cnt_nxt       = r_period - CNT_W'(1);
                  end else if (w_last && !r_loop) begin
                     w_state_nxt     = S_DONE;
                     w_seq_data_nxt  = '0;
                     w_seq_valid_nxt = 1'b0;
                     w_busy_nxt      = 1'b0;
                     w_done_nxt      = 1'b1;
                  end else begin
                     w_seq_data_nxt  = r_buf;
                     w_seq_valid_nxt = 1'b1;
                     w_strobe_nxt    = 1'b1;
                     w_index_nxt     = w_next_addr;
                     w_cnt_nxt       = r_period - CNT_W'(1);
`ifdef SEQ_FETCH_LOOP_EN
                     if (w_last && (r_repeat != '1)) begin
                        w_repeat_nxt = r_repeat + CNT_W'(1);
                     end
`endif
                  end
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               // Held until enable falls; a new rising edge is needed to restart.
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_en_prev   <= 1'b0;
         r_period    <= '0;
         r_len       <= '0;
         r_loop      <= 1'b0;
         r_cnt       <= '0;
         r_first     <= 1'b0;
         r_rd_v1     <= 1'b0;
         r_buf       <= '0;
         r_bram_en   <= 1'b0;
         r_bram_addr <= '0;
         r_seq_data  <= '0;
         r_seq_valid <= 1'b0;
         r_strobe    <= 1'b0;
         r_index     <= '0;
         r_repeat    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_en_prev   <= enable;
         r_period    <= w_period_nxt;
         r_len       <= w_len_nxt;
         r_loop      <= w_loop_nxt;
         r_cnt       <= w_cnt_nxt;
         r_first     <= w_first_nxt;
         r_rd_v1     <= r_bram_en;
         r_buf       <= w_buf_nxt;
         r_bram_en   <= w_bram_en_nxt;
         r_bram_addr <= w_bram_addr_nxt;
         r_seq_data  <= w_seq_data_nxt;
         r_seq_valid <= w_seq_valid_nxt;
         r_strobe    <= w_strobe_nxt;
         r_index     <= w_index_nxt;
         r_repeat    <= w_repeat_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign bram_en      = r_bram_en;
   assign bram_addr    = r_bram_addr;
   assign seq_data     = r_seq_data;
   assign seq_valid    = r_seq_valid;
   assign step_strobe  = r_strobe;
   assign step_index   = r_index;
   assign repeat_count = r_repeat;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_sequence_step_fetcher.sv
// Directed testbench for sequence_step_fetcher with a one-cycle-latency BRAM model.
module tb_sequence_step_fetcher;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned CNT_W  = 32;

   logic              clk;
   logic              aresetn;
   logic              enable;
   logic [CNT_W-1:0]  step_period;
   logic [ADDR_W:0]   seq_len;
   logic              loop_mode;
   logic              bram_en;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_rdata;
   logic [DATA_W-1:0] seq_data;
   logic              seq_valid;
   logic              step_strobe;
   logic [ADDR_W-1:0] step_index;
   logic [CNT_W-1:0]  repeat_count;
   logic              busy;
   logic              done;

   int n_total;
   int n_bad;

   // Observation record for one run, cycle 0 = edge that samples enable's rising edge.
   int                q_cyc[$];
   logic [DATA_W-1:0] q_dat[$];
   logic [ADDR_W-1:0] q_idx[$];
   logic [CNT_W-1:0]  q_rep[$];
   int                n_ren;
   int                done_cyc;

   sequence_step_fetcher dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .enable       (enable),
      .step_period  (step_period),
      .seq_len      (seq_len),
      .loop_mode    (loop_mode),
      .bram_en      (bram_en),
      .bram_addr    (bram_addr),
      .bram_rdata   (bram_rdata),
      .seq_data     (seq_data),
      .seq_valid    (seq_valid),
      .step_strobe  (step_strobe),
      .step_index   (step_index),
      .repeat_count (repeat_count),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] word(input int k);
      return {32'(k), 32'hFEED_0000 ^ 32'(k), 32'h1234_5678 + 32'(k), ~32'(k)};
   endfunction

   // BRAM: registered read, data valid one clock after bram_en.
   always @(posedge clk) begin
      if (bram_en) bram_rdata <= word(32'(bram_addr));
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic observe(input int n);
      q_cyc.delete();
      q_dat.delete();
      q_idx.delete();
      q_rep.delete();
      n_ren    = 0;
      done_cyc = -1;
      for (int c = 0; c < n; c++) begin
         tick();
         if (step_strobe) begin
            q_cyc.push_back(c);
            q_dat.push_back(seq_data);
            q_idx.push_back(step_index);
            q_rep.push_back(repeat_count);
         end
         if (bram_en) n_ren++;
         if (done && (done_cyc < 0)) done_cyc = c;
      end
   endtask

   task automatic go_idle();
      enable = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      n_total     = 0;
      n_bad       = 0;
      aresetn     = 1'b0;
      enable      = 1'b0;
      step_period = 32'd10;
      seq_len     = 15'd3;
      loop_mode   = 1'b0;

      // Reset values.
      tick();
      tick();
      chk("rst_seq_data", 128'(seq_data), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_bram_en", 128'(bram_en), 128'd0);
      aresetn = 1'b1;
      tick();

      // Three steps, P=10, no loop.
      enable = 1'b1;
      observe(45);
      chk("t2_nstrobe", 128'(q_cyc.size()), 128'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_cyc%0d", i), 128'(q_cyc[i]), 128'(3 + 10 * i));
         chk($sformatf("t2_dat%0d", i), q_dat[i], word(i));
         chk($sformatf("t2_idx%0d", i), 128'(q_idx[i]), 128'(i));
      end
      chk("t2_done_cyc", 128'(done_cyc), 128'd33);
      chk("t2_done_hold", 128'(done), 128'd1);
      chk("t2_data_zero", seq_data, 128'd0);
      chk("t2_valid_zero", 128'(seq_valid), 128'd0);
      chk("t2_busy_zero", 128'(busy), 128'd0);
      chk("t2_nread", 128'(n_ren), 128'd3);
      go_idle();
      chk("t2_done_clr", 128'(done), 128'd0);

      // P=1 clamps to 4.
      step_period = 32'd1;
      enable = 1'b1;
      observe(20);
      chk("t3_nstrobe", 128'(q_cyc.size()), 128'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t3_cyc%0d", i), 128'(q_cyc[i]), 128'(3 + 4 * i));
         chk($sformatf("t3_dat%0d", i), q_dat[i], word(i));
      end
      chk("t3_nread", 128'(n_ren), 128'd3);
      chk("t3_done_cyc", 128'(done_cyc), 128'd15);
      go_idle();

      // Two steps, loop requested, P=5.
      step_period = 32'd5;
      seq_len     = 15'd2;
      loop_mode   = 1'b1;
      enable      = 1'b1;
      observe(20);
`ifdef SEQ_FETCH_LOOP_EN
      chk("t4_nstrobe", 128'(q_cyc.size()), 128'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_cyc%0d", i), 128'(q_cyc[i]), 128'(3 + 5 * i));
         chk($sformatf("t4_dat%0d", i), q_dat[i], word(i % 2));
         chk($sformatf("t4_rep%0d", i), 128'(q_rep[i]), 128'(i / 2));
      end
      chk("t4_no_done", 128'(done_cyc), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
`else
      chk("t4_nstrobe", 128'(q_cyc.size()), 128'd2);
      chk("t4_dat1", q_dat[1], word(1));
      chk("t4_done_cyc", 128'(done_cyc), 128'd13);
      chk("t4_rep", 128'(repeat_count), 128'd0);
`endif
      go_idle();
      loop_mode = 1'b0;

      // Abort on the second strobe, then restart.
      step_period = 32'd6;
      seq_len     = 15'd3;
      enable      = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      chk("t5_strobe2", 128'(step_strobe), 128'd1);
      chk("t5_dat2", seq_data, word(1));
      enable = 1'b0;
      tick();
      chk("t5_abort_data", seq_data, 128'd0);
      chk("t5_abort_valid", 128'(seq_valid), 128'd0);
      chk("t5_abort_done", 128'(done), 128'd0);
      chk("t5_abort_busy", 128'(busy), 128'd0);
      tick();
      enable = 1'b1;
      observe(6);
      chk("t5_re_nstrobe", 128'(q_cyc.size()), 128'd1);
      chk("t5_re_cyc", 128'(q_cyc[0]), 128'd3);
      chk("t5_re_dat", q_dat[0], word(0));
      go_idle();

      // Empty sequence, loop requested.
      seq_len   = 15'd0;
      loop_mode = 1'b1;
      enable    = 1'b1;
      observe(10);
      chk("t6_done_cyc", 128'(done_cyc), 128'd0);
      chk("t6_nstrobe", 128'(q_cyc.size()), 128'd0);
      chk("t6_nread", 128'(n_ren), 128'd0);
      chk("t6_done_hold", 128'(done), 128'd1);
      go_idle();
      loop_mode = 1'b0;

      // Asynchronous reset in the middle of a run.
      seq_len     = 15'd3;
      step_period = 32'd10;
      enable      = 1'b1;
      observe(8);
      chk("t1_pre_valid", 128'(seq_valid), 128'd1);
      #1;
      aresetn = 1'b0;
      enable  = 1'b0;
      #1;
      chk("t1_rst_data", seq_data, 128'd0);
      chk("t1_rst_valid", 128'(seq_valid), 128'd0);
      chk("t1_rst_busy", 128'(busy), 128'd0);
      chk("t1_rst_idx", 128'(step_index), 128'd0);
      tick();
      aresetn = 1'b1;
      observe(8);
      chk("t1_post_nstrobe", 128'(q_cyc.size()), 128'd0);
      chk("t1_post_nread", 128'(n_ren), 128'd0);
      chk("t1_post_busy", 128'(busy), 128'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
